// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and defaults: reset/exception vectors, the nop encoding,
// the fetch FSM states and the IF/ID payload.
package mips_pkg;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0004;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

  typedef enum logic [1:0] {BOOT, RUN, HOLD} fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: pipeline control in, imem port and IF/ID state out.
// FETCH_EXC_EN adds the exception request and EPC.
interface fetch_pc_unit_if;
  logic        stall;
  logic        ex_is_branch;
  logic [31:0] ex_branch_target;
  logic [31:0] ex_pc_plus4;
  logic        id_jump;
  logic [31:0] id_jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        flush_id_ex;
  logic [15:0] redirect_cnt;
`ifdef FETCH_EXC_EN
  logic        exc_req;
  logic [31:0] epc;
`endif

  // master = the fetch unit, slave = the surrounding pipeline / memory
  modport master (
    input  stall, ex_is_branch, ex_branch_target, ex_pc_plus4,
           id_jump, id_jump_target, imem_rdata,
    output imem_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid,
           flush_id_ex, redirect_cnt
`ifdef FETCH_EXC_EN
    , input exc_req, output epc
`endif
  );

  modport slave (
    output stall, ex_is_branch, ex_branch_target, ex_pc_plus4,
           id_jump, id_jump_target, imem_rdata,
    input  imem_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid,
           flush_id_ex, redirect_cnt
`ifdef FETCH_EXC_EN
    , output exc_req, input epc
`endif
  );
endinterface

// File: rtl/fetch_pc_unit_if_id_reg.sv
// IF/ID pipeline register: reset > bubble > load > hold.
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      q.instr    <= NOP_INSTR;
      q.pc_plus4 <= '0;
      q.valid    <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// IF stage: PC, next-PC priority mux, BOOT/RUN/HOLD FSM, redirect counter, IF/ID register.
// FETCH_EXC_EN adds an exception redirect to EXC_VECTOR that outranks a taken branch.
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF
`ifdef FETCH_EXC_EN
  , parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
`endif
) (
  input logic             clk,
  input logic             reset,
  fetch_pc_unit_if.master bus
);
  fetch_state_e state, state_nxt;
  logic [31:0]  pc_q, pc_nxt, pc_plus4;
  logic [15:0]  cnt_q;
  logic         taken, jump, active;
  logic         flush, cnt_inc, ifid_load, ifid_bubble;
  if_id_t       fetch_d, if_id_q;

  assign pc_plus4 = pc_q + 32'd4;
  assign taken    = bus.ex_is_branch && (bus.ex_branch_target != bus.ex_pc_plus4);
  assign jump     = bus.id_jump && if_id_q.valid;
  assign active   = (state != BOOT);

  assign fetch_d.instr    = bus.imem_rdata;
  assign fetch_d.pc_plus4 = pc_plus4;
  assign fetch_d.valid    = active;

  // BOOT fetches once with valid low, ignoring redirects and stalls
  always_comb begin
    state_nxt   = RUN;
    pc_nxt      = pc_plus4;
    ifid_load   = 1'b1;
    ifid_bubble = 1'b0;
    flush       = 1'b0;
    cnt_inc     = 1'b0;
    if (!active) begin
      state_nxt = RUN;
    end
`ifdef FETCH_EXC_EN
    else if (bus.exc_req) begin
      pc_nxt      = EXC_VECTOR;
      ifid_bubble = 1'b1;
      flush       = 1'b1;
    end
`endif
    else if (taken) begin
      pc_nxt      = bus.ex_branch_target;
      ifid_bubble = 1'b1;
      flush       = 1'b1;
      cnt_inc     = 1'b1;
    end else if (bus.stall) begin
      state_nxt = HOLD;
      pc_nxt    = pc_q;
      ifid_load = 1'b0;
    end else if (jump) begin
      pc_nxt      = bus.id_jump_target;
      ifid_bubble = 1'b1;
      cnt_inc     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      if (cnt_inc) cnt_q <= sat_inc16(cnt_q);
    end
  end

`ifdef FETCH_EXC_EN
  logic [31:0] epc_q;
  // EPC names the instruction in ID, or the fetch PC when ID holds a bubble
  always_ff @(posedge clk) begin
    if (reset)                      epc_q <= '0;
    else if (active && bus.exc_req) epc_q <= if_id_q.valid ? if_id_q.pc_plus4 - 32'd4 : pc_q;
  end
  assign bus.epc = epc_q;
`endif

  if_id_reg u_if_id (
    .clk    (clk),
    .reset  (reset),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (fetch_d),
    .q      (if_id_q)
  );

  assign bus.imem_addr      = pc_q;
  assign bus.pc             = pc_q;
  assign bus.if_id_instr    = if_id_q.instr;
  assign bus.if_id_pc_plus4 = if_id_q.pc_plus4;
  assign bus.if_id_valid    = if_id_q.valid;
  assign bus.flush_id_ex    = flush && !reset;
  assign bus.redirect_cnt   = cnt_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed + random bench for fetch_pc_unit against a per-cycle behavioural model.
// Exception steps are compiled only with FETCH_EXC_EN.
module tb_fetch_pc_unit;
  localparam logic [31:0] EXC_VEC = 32'h8000_0004;

  logic clk = 1'b0;
  logic reset;
  logic exc_in = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fetch_pc_unit_if bus ();

  fetch_pc_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // instruction memory: word at addr reads back as addr|1
  assign bus.imem_rdata = bus.imem_addr | 32'h1;
`ifdef FETCH_EXC_EN
  assign bus.exc_req = exc_in;
`endif

  // model state
  logic [31:0] m_pc, m_instr, m_pp4, m_epc;
  logic        m_valid, m_boot;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic step(input logic rst, input logic stl, input logic br,
                      input logic [31:0] tgt, input logic [31:0] pp4,
                      input logic jmp, input logic [31:0] jt);
    logic tk;
    reset                = rst;
    bus.stall            = stl;
    bus.ex_is_branch     = br;
    bus.ex_branch_target = tgt;
    bus.ex_pc_plus4      = pp4;
    bus.id_jump          = jmp;
    bus.id_jump_target   = jt;
    #1;
    tk = br && (tgt != pp4);
    chk("flush_id_ex", {31'b0, bus.flush_id_ex},
        {31'b0, !rst && !m_boot && (tk || exc_in)});
    if (!rst) chk("imem_addr", bus.imem_addr, m_pc);
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
      m_cnt = 16'h0; m_epc = 32'h0; m_boot = 1'b1;
    end else if (m_boot) begin
      m_instr = m_pc | 32'h1; m_pp4 = m_pc + 32'd4; m_valid = 1'b0;
      m_pc = m_pc + 32'd4; m_boot = 1'b0;
    end else if (exc_in) begin
      m_epc = m_valid ? m_pp4 - 32'd4 : m_pc;
      m_pc = EXC_VEC; m_instr = 32'h0; m_valid = 1'b0;
    end else if (tk) begin
      m_pc = tgt; m_instr = 32'h0; m_valid = 1'b0; m_cnt = sat(m_cnt);
    end else if (stl) begin
      // frozen
    end else if (jmp && m_valid) begin
      m_pc = jt; m_instr = 32'h0; m_valid = 1'b0; m_cnt = sat(m_cnt);
    end else begin
      m_instr = m_pc | 32'h1; m_pp4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
    #1;
    chk("pc", bus.pc, m_pc);
    chk("if_id_instr", bus.if_id_instr, m_instr);
    chk("if_id_valid", {31'b0, bus.if_id_valid}, {31'b0, m_valid});
    if (m_valid || rst) chk("if_id_pc_plus4", bus.if_id_pc_plus4, m_valid ? m_pp4 : 32'h0);
    chk("redirect_cnt", {16'b0, bus.redirect_cnt}, {16'b0, m_cnt});
`ifdef FETCH_EXC_EN
    chk("epc", bus.epc, m_epc);
`endif
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    m_boot = 1'b0; m_pc = 32'h0;
    // reset held during a stall and a taken branch: reset must win, no flush
    step(1'b1, 1'b1, 1'b1, 32'h40, 32'h14, 1'b1, 32'h100);
    step(1'b1, 1'b1, 1'b1, 32'h40, 32'h14, 1'b0, 32'h0);
    // BOOT then free run: pc 0,4,8,12,16
    repeat (4) idle();
    chk("pc_after_boot", bus.pc, 32'h10);
    // taken branch
    step(1'b0, 1'b0, 1'b1, 32'h40, 32'h14, 1'b0, 32'h0);
    chk("pc_taken", bus.pc, 32'h40);
    chk("cnt_taken", {16'b0, bus.redirect_cnt}, 32'h1);
    idle();
    // not-taken branch: target equals pc+4
    step(1'b0, 1'b0, 1'b1, 32'h14, 32'h14, 1'b0, 32'h0);
    // stall two cycles with a pending jump, then release
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h100);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h100);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h100);
    chk("pc_jump", bus.pc, 32'h100);
    idle(); idle();
    // stall and taken together: branch wins, then FSM must run freely
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h200, 32'h80, 1'b0, 32'h0);
    idle(); idle();
    // wrap at top of address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h10, 1'b0, 32'h0);
    idle();
    chk("pc_wrap", bus.pc, 32'h0);
    idle();
    // reset in the middle of a redirect
    step(1'b1, 1'b0, 1'b1, 32'h300, 32'h20, 1'b0, 32'h0);
    idle(); idle(); idle();
`ifdef FETCH_EXC_EN
    exc_in = 1'b1;
    step(1'b0, 1'b0, 1'b1, 32'h40, 32'h14, 1'b0, 32'h0);
    exc_in = 1'b0;
    chk("pc_exc", bus.pc, EXC_VEC);
    idle(); idle();
`endif
    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic        r, s, b, j;
      logic [31:0] pp4, tgt;
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 25);
      b   = ($urandom_range(0, 99) < 20);
      j   = ($urandom_range(0, 99) < 20);
      pp4 = $urandom;
      tgt = $urandom_range(0, 1) ? pp4 : ($urandom & 32'hFFFF_FFFC);
`ifdef FETCH_EXC_EN
      exc_in = ($urandom_range(0, 99) < 3);
`endif
      step(r, s, b, tgt, pp4, j, $urandom & 32'hFFFF_FFFC);
    end
    exc_in = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
